loop_over_all_nibbles: RTL and testbench

LOOP_OVER_ALL_NIBBLES -- requirements
Module: loop_over_all_nibbles

---
 rtl/loop_over_all_nibbles.sv | 142 ++++++++++++++
 tb/tb_loop_over_all_nibbles.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial ALU: one 4-bit slice of word1 op word2 is processed per clock.
// Nibbles above the last mandatory index are only processed for ADD/SUB while
// a carry or a nonzero sign fill could still change them.
module loop_over_all_nibbles #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             loop_perm_to_count,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] word1,
   input  logic [WIDTH-1:0] word2,
   input  logic [WIDTH-1:0] preinit_result,
   input  logic [2:0]       loop_nibbles_number,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             result_carry,
   output logic [2:0]       curr_nibble_idx
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam logic [2:0]  LastIdx = 3'(NIBBLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [2:0]       idx_q, idx_d;

   logic [2:0] op;
   logic       is_sub;
   logic       is_logic;
   logic [2:0] cur_idx;
   logic [4:0] bit_base;
   logic       cin;
   logic       sign;
   logic       fill_nz;
   logic [3:0] a_nib;
   logic [3:0] b_raw;
   logic [3:0] b_nib;
   logic [4:0] sum;
   logic [3:0] nib_res;
   logic       cout;
   logic       finish;
   logic       process;

   // Datapath for the nibble handled at the coming edge and the finish decision.
   always_comb begin
      op       = ctrl[2:0];
      is_sub   = (op == OpSub);
      is_logic = (op == OpAnd) || (op == OpOr) || (op == OpXor);
      // Outside RUN the idx register is parked at 0, so IDLE always starts at nibble 0.
      cur_idx  = (state_q == RUN) ? idx_q : 3'd0;
      bit_base = {cur_idx, 2'b00};
      cin      = (state_q == RUN) ? carry_q : ctrl[3];
      sign     = word2[{loop_nibbles_number, 2'b11}];
      // Effective fill after the SUB inversion; a zero fill cannot change upper nibbles.
      fill_nz  = sign ^ is_sub;
      a_nib    = word1[bit_base +: 4];
      b_raw    = (cur_idx > loop_nibbles_number) ? {4{sign}} : word2[bit_base +: 4];
      b_nib    = is_sub ? ~b_raw : b_raw;
      sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
      case (op)
         OpAnd:   begin nib_res = a_nib & b_raw; cout = 1'b0;   end
         OpOr:    begin nib_res = a_nib | b_raw; cout = 1'b0;   end
         OpXor:   begin nib_res = a_nib ^ b_raw; cout = 1'b0;   end
         default: begin nib_res = sum[3:0];      cout = sum[4]; end
      endcase
      finish = (cur_idx == LastIdx) ||
               ((cur_idx >= loop_nibbles_number) && (is_logic || (!cout && !fill_nz)));
   end

   // Next-state and register updates for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      process  = loop_perm_to_count && (state_q != DONE);

      case (state_q)
         IDLE, RUN: begin
            if (process) begin
               if (state_q == IDLE) begin
                  result_d = preinit_result;
               end
               result_d[bit_base +: 4] = nib_res;
               carry_d = cout;
               if (finish) begin
                  state_d = DONE;
                  idx_d   = 3'd0;
               end else begin
                  state_d = RUN;
                  idx_d   = cur_idx + 3'd1;
               end
            end else begin
               // Request dropped: abort, keeping the partial result.
               state_d = IDLE;
               idx_d   = 3'd0;
            end
         end
         DONE: begin
            if (!loop_perm_to_count) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= 3'd0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
      end
   end

   assign busy            = loop_perm_to_count && (state_q != DONE) && !rst;
   assign result          = result_q;
   assign result_carry    = carry_q;
   assign curr_nibble_idx = idx_q;

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Randomized and directed bench for loop_over_all_nibbles against a word-level model.
module tb_loop_over_all_nibbles;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [3:0]  ctrl;
   logic [31:0] word1, word2, preinit;
   logic [2:0]  nsel;
   logic [31:0] result;
   logic        busy;
   logic        result_carry;
   logic [2:0]  idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   loop_over_all_nibbles #(.WIDTH(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .loop_perm_to_count  (req),
      .ctrl                (ctrl),
      .word1               (word1),
      .word2               (word2),
      .preinit_result      (preinit),
      .loop_nibbles_number (nsel),
      .result              (result),
      .busy                (busy),
      .result_carry        (result_carry),
      .curr_nibble_idx     (idx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Word-level model: full-width arithmetic on the sign-extended operand, then the
   // number of processed nibbles follows from the carry vector and the fill value.
   function automatic void model(input logic [3:0] c, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [2:0] n,
                                 output logic [31:0] proc, output int k, output logic cy);
      int               sh;
      logic signed [31:0] t;
      logic [31:0]      w2e;
      logic [32:0]      full;
      logic [32:0]      cv;
      sh  = 28 - 4 * int'(n);
      t   = w2 << sh;
      w2e = t >>> sh;
      case (c[2:0])
         3'd2: begin proc = w1 & w2; k = int'(n) + 1; cy = 1'b0; end
         3'd3: begin proc = w1 | w2; k = int'(n) + 1; cy = 1'b0; end
         3'd4: begin proc = w1 ^ w2; k = int'(n) + 1; cy = 1'b0; end
         default: begin
            if (c[2:0] == 3'd1) w2e = ~w2e;
            full = {1'b0, w1} + {1'b0, w2e} + {32'd0, c[3]};
            proc = full[31:0];
            cv   = full ^ {1'b0, w1} ^ {1'b0, w2e};
            k    = int'(n) + 1;
            if (w2e[31]) k = 8;
            else while (k < 8 && cv[4*k]) k++;
            cy = cv[4*k];
         end
      endcase
   endfunction

   function automatic logic [31:0] partial(input logic [31:0] proc, input logic [31:0] pre,
                                           input int c);
      logic [31:0] mask;
      mask = (c >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * c)) - 32'h1);
      return (proc & mask) | (pre & ~mask);
   endfunction

   task automatic drive(input logic [3:0] c, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] pre, input logic [2:0] n);
      ctrl = c; word1 = w1; word2 = w2; preinit = pre; nsel = n; req = 1'b1;
   endtask

   // One full request/response cycle with per-cycle index and partial-result checks.
   task automatic run_op(input logic [3:0] c, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] pre, input logic [2:0] n);
      logic [31:0] proc, exp;
      logic        cy;
      int          k, cnt;
      bit          done;
      model(c, w1, w2, n, proc, k, cy);
      exp = partial(proc, pre, k);
      @(posedge clk); #1;
      drive(c, w1, w2, pre, n);
      cnt  = 0;
      done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk);
         if (!busy) done = 1;
         else begin
            chk("curr_idx", {29'd0, idx}, 32'(cnt));
            if (cnt > 0) chk("partial", result, partial(proc, pre, cnt));
            cnt++;
         end
      end
      chk("busy_cycles", 32'(cnt), 32'(k));
      chk("result", result, exp);
      chk("carry", {31'd0, result_carry}, {31'd0, cy});
      chk("idx_done", {29'd0, idx}, 32'd0);
      @(negedge clk);
      chk("busy_held", {31'd0, busy}, 32'd0);
      chk("result_held", result, exp);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("busy_release", {31'd0, busy}, 32'd0);
   endtask

   task automatic pin(input string name, input logic [3:0] c, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] pre, input logic [2:0] n,
                      input int ek, input logic [31:0] er, input logic ec);
      logic [31:0] proc;
      logic        cy;
      int          k;
      model(c, w1, w2, n, proc, k, cy);
      chk({name, "_k"}, 32'(k), 32'(ek));
      chk({name, "_res"}, partial(proc, pre, k), er);
      chk({name, "_cy"}, {31'd0, cy}, {31'd0, ec});
   endtask

   initial begin
      logic [31:0] proc, w1r, w2r;
      logic        cy;
      int          k;

      rst = 1'b1;
      drive(4'h0, 32'h1234_5678, 32'h1, 32'hDEAD_BEEF, 3'd0);
      @(negedge clk);
      chk("busy_in_reset", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("rst_result", result, 32'd0);
      chk("rst_carry", {31'd0, result_carry}, 32'd0);
      chk("rst_idx", {29'd0, idx}, 32'd0);
      req = 1'b0;
      rst = 1'b0;

      // Hand-computed expectations that pin the model.
      pin("pc_inc", 4'h0, 32'h0000_0AEF, 32'h4, 32'h0000_0AEF, 3'd0, 2, 32'h0000_0AF3, 1'b0);
      pin("neg_imm", 4'h0, 32'h0, 32'hFFFF_F800, 32'h0, 3'd2, 8, 32'hFFFF_F800, 1'b0);
      pin("small", 4'h0, 32'd123, 32'd2, 32'h0, 3'd2, 3, 32'd125, 1'b0);
      pin("xor", 4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 3'd7, 8, 32'hFF00_FF00, 1'b0);
      pin("and", 4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h1234_5678, 3'd1, 2, 32'h1234_56F0,
          1'b0);
      pin("sub", 4'h9, 32'h0, 32'h1, 32'h0, 3'd7, 8, 32'hFFFF_FFFF, 1'b0);

      run_op(4'h0, 32'h0000_0AEF, 32'h4, 32'h0000_0AEF, 3'd0);
      run_op(4'h0, 32'h0, 32'hFFFF_F800, 32'h0, 3'd2);
      run_op(4'h0, 32'd123, 32'd2, 32'h0, 3'd2);
      run_op(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 3'd7);
      run_op(4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h1234_5678, 3'd1);
      run_op(4'h9, 32'h0, 32'h1, 32'h0, 3'd7);
      run_op(4'h9, 32'd5, 32'd1, 32'hAAAA_AAAA, 3'd0);

      // Abort mid-RUN after two nibbles: partial result kept.
      model(4'h4, 32'h1234_5678, 32'hFFFF_FFFF, 3'd7, proc, k, cy);
      @(posedge clk); #1;
      drive(4'h4, 32'h1234_5678, 32'hFFFF_FFFF, 32'h5555_5555, 3'd7);
      @(posedge clk);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("abort_result", result, partial(proc, 32'h5555_5555, 2));
      chk("abort_idx", {29'd0, idx}, 32'd0);

      // Reset after three nibbles of a long carry chain.
      @(posedge clk); #1;
      drive(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req = 1'b0;
      chk("midrst_result", result, 32'd0);
      chk("midrst_carry", {31'd0, result_carry}, 32'd0);
      chk("midrst_idx", {29'd0, idx}, 32'd0);
      run_op(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'd0);

      // Randomized operations, biased toward long carry chains.
      for (int i = 0; i < 60; i++) begin
         w1r = $urandom;
         w2r = $urandom;
         if ($urandom_range(0, 2) == 0) w1r = w1r | 32'hFFFF_FF00;
         if ($urandom_range(0, 2) == 0) w2r = w2r & 32'h0000_00FF;
         run_op(4'($urandom_range(0, 15)), w1r, w2r, $urandom, 3'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
